// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared CPU constants for the register file and scoreboard.
// Holds default widths, the address-width helper and the zero-register index.
package regfile_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    // Address width for n registers, never narrower than one bit.
    function automatic int aw_of(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: writeback, issue and read-port bundle of the register file.
// master drives we/wa/wd/ra/iss_*; slave returns rd/rbusy/nbusy.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2
);
    localparam int AW = aw_of(NREG);

    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [AW:0]         nbusy;

    modport master (
        output we, wa, wd, ra, iss_valid, iss_rd,
        input  rd, rbusy, nbusy
    );

    modport slave (
        input  we, wa, wd, ra, iss_valid, iss_rd,
        output rd, rbusy, nbusy
    );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with range check and bypass.
// ra_i/rf_i/busy_i/we_i/wa_i/wd_i in; rd_o data and rbusy_o pending flag out.
module regfile_rdport #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]        ra_i,
    input  logic [NREG*XLEN-1:0] rf_i,
    input  logic [NREG-1:0]      busy_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        wa_i,
    input  logic [XLEN-1:0]      wd_i,
    output logic [XLEN-1:0]      rd_o,
    output logic                 rbusy_o
);

    logic in_rng;
    logic hit;

    assign in_rng = int'(ra_i) < NREG;
    // we_i is pre-qualified: valid, non-zero address and not in reset.
    assign hit    = (BYPASS != 0) && we_i && (wa_i == ra_i);

    always_comb begin
        rd_o    = '0;
        rbusy_o = 1'b0;
        if (hit) begin
            rd_o = wd_i;
        end else if (in_rng) begin
            rd_o    = rf_i[int'(ra_i)*XLEN +: XLEN];
            rbusy_o = busy_i[ra_i];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy scoreboard and busy count.
// clk/rst plain; bus (slave) carries writeback, issue, reads, rbusy, nbusy.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    localparam int AW = aw_of(NREG);

    logic [NREG*XLEN-1:0] rf_q;
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [AW:0]          nbusy_q;
    logic [AW:0]          nbusy_d;
    logic                 wr_ok;
    logic                 iss_ok;
    logic                 wr_fwd;
    logic [NRD*XLEN-1:0]  rd_w;

    assign wr_ok  = bus.we && (int'(bus.wa) != REG_ZERO)
                    && (int'(bus.wa) < NREG);
    assign iss_ok = bus.iss_valid && (int'(bus.iss_rd) != REG_ZERO)
                    && (int'(bus.iss_rd) < NREG);
    // No forwarding while reset holds everything at zero.
    assign wr_fwd = wr_ok && !rst;

    // Clear on retire first so a same-edge issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[bus.wa] = 1'b0;
        if (iss_ok) busy_d[bus.iss_rd] = 1'b1;
    end

    always_comb begin
        nbusy_d = '0;
        for (int i = 0; i < NREG; i++) begin
            nbusy_d = nbusy_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q    <= '0;
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            if (wr_ok) rf_q[int'(bus.wa)*XLEN +: XLEN] <= bus.wd;
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        regfile_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .ra_i    (bus.ra[g*AW +: AW]),
            .rf_i    (rf_q),
            .busy_i  (busy_q),
            .we_i    (wr_fwd),
            .wa_i    (bus.wa),
            .wd_i    (bus.wd),
            .rd_o    (rd_w[g*XLEN +: XLEN]),
            .rbusy_o (bus.rbusy[g])
        );
    end

    assign bus.rd    = rd_w;
    assign bus.nbusy = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb in three configurations.
// a: defaults, b: BYPASS=0, c: NREG=24; all share one stimulus stream.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic        iss_valid;
    logic [4:0]  iss_rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) if_a ();
    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) if_b ();
    regfile_sb_if #(.XLEN(32), .NREG(24), .NRD(2)) if_c ();

    assign if_a.we = we;  assign if_a.wa = wa;  assign if_a.wd = wd;
    assign if_a.ra = ra;  assign if_a.iss_valid = iss_valid;
    assign if_a.iss_rd = iss_rd;
    assign if_b.we = we;  assign if_b.wa = wa;  assign if_b.wd = wd;
    assign if_b.ra = ra;  assign if_b.iss_valid = iss_valid;
    assign if_b.iss_rd = iss_rd;
    assign if_c.we = we;  assign if_c.wa = wa;  assign if_c.wd = wd;
    assign if_c.ra = ra;  assign if_c.iss_valid = iss_valid;
    assign if_c.iss_rd = iss_rd;

    regfile_sb #(.NRD(2), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    regfile_sb #(.NRD(2), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    regfile_sb #(.NREG(24), .NRD(2), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        rst = 1'b1;
        ra  = '0;
        idle();
        tick();
        tick();
        chk("rst_nbusy", 64'(if_a.nbusy), 64'd0);
        chk("rst_rbusy", 64'(if_a.rbusy), 64'd0);

        // Write presented in the deassert cycle lands on the next edge.
        rst = 1'b0;
        we = 1'b1; wa = 5'd6; wd = 32'h66;
        tick();
        idle();
        ra[4:0] = 5'd6;
        #1 chk("deassert_wr", 64'(if_b.rd[31:0]), 64'h66);

        // x5 then asynchronous reset mid-cycle.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        idle();
        ra[4:0] = 5'd5;
        #1 chk("x5_wr", 64'(if_a.rd[31:0]), 64'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk("rst_rd", 64'(if_a.rd[31:0]), 64'd0);
        chk("rst_nb", 64'(if_a.nbusy), 64'd0);
        we = 1'b1; wa = 5'd5; wd = 32'h1234;
        #1 chk("rst_byp", 64'(if_a.rd[31:0]), 64'd0);
        chk("rst_byp_rb", 64'(if_a.rbusy), 64'd0);
        tick();
        chk("rst_hold", 64'(if_a.rd[31:0]), 64'd0);
        idle();
        rst = 1'b0;
        tick();

        // Bypass vs no bypass.
        we = 1'b1; wa = 5'd7; wd = 32'h12345678;
        ra[4:0] = 5'd7;
        #1 chk("byp_rd", 64'(if_a.rd[31:0]), 64'h12345678);
        chk("byp_rb", 64'(if_a.rbusy[0]), 64'd0);
        chk("nobyp_old", 64'(if_b.rd[31:0]), 64'd0);
        tick();
        idle();
        chk("nobyp_new", 64'(if_b.rd[31:0]), 64'h12345678);

        // x0 writes and issues are ignored.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        ra[4:0] = 5'd0;
        #1 chk("x0_byp", 64'(if_a.rd[31:0]), 64'd0);
        tick();
        idle();
        chk("x0_rd", 64'(if_a.rd[31:0]), 64'd0);
        chk("x0_rb", 64'(if_a.rbusy[0]), 64'd0);
        chk("x0_nb", 64'(if_a.nbusy), 64'd0);

        // Scoreboard: issue x3, x4, retire x3.
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd4;
        tick();
        idle();
        ra = {5'd4, 5'd3};
        #1 chk("sb_nb2", 64'(if_a.nbusy), 64'd2);
        chk("sb_rb11", 64'(if_a.rbusy), 64'b11);
        we = 1'b1; wa = 5'd3; wd = 32'h33;
        #1 chk("sb_fwd_rb", 64'(if_a.rbusy), 64'b10);
        chk("sb_nofwd_rb", 64'(if_b.rbusy), 64'b11);
        tick();
        idle();
        chk("sb_rb10", 64'(if_a.rbusy), 64'b10);
        chk("sb_nb1", 64'(if_a.nbusy), 64'd1);
        chk("sb_x3", 64'(if_a.rd[31:0]), 64'h33);

        // Collision on already-busy x9: set wins, data lands.
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        chk("col_pre_nb", 64'(if_a.nbusy), 64'd2);
        iss_valid = 1'b1; iss_rd = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h55;
        tick();
        idle();
        ra[4:0] = 5'd9;
        #1 chk("col_rd", 64'(if_a.rd[31:0]), 64'h55);
        chk("col_rb", 64'(if_a.rbusy[0]), 64'd1);
        chk("col_nb", 64'(if_a.nbusy), 64'd2);

        // Re-issue to busy x4 keeps the count.
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        idle();
        chk("reiss_nb", 64'(if_a.nbusy), 64'd2);

        // Write to non-busy x10 leaves busy alone.
        we = 1'b1; wa = 5'd10; wd = 32'hAA;
        tick();
        idle();
        ra[4:0] = 5'd10;
        #1 chk("nb_wr_rd", 64'(if_a.rd[31:0]), 64'hAA);
        chk("nb_wr_nb", 64'(if_a.nbusy), 64'd2);

        // Out-of-range address 30 on the 24-entry file.
        ra[4:0] = 5'd30;
        iss_valid = 1'b1; iss_rd = 5'd30;
        tick();
        idle();
        chk("oor_iss_nb_c", 64'(if_c.nbusy), 64'd2);
        chk("oor_iss_nb_a", 64'(if_a.nbusy), 64'd3);
        chk("oor_rb_c", 64'(if_c.rbusy[0]), 64'd0);
        we = 1'b1; wa = 5'd30; wd = 32'h77;
        #1 chk("oor_byp_c", 64'(if_c.rd[31:0]), 64'd0);
        tick();
        idle();
        #1 chk("oor_rd_c", 64'(if_c.rd[31:0]), 64'd0);
        chk("oor_nb_c", 64'(if_c.nbusy), 64'd2);
        chk("in_rd_a", 64'(if_a.rd[31:0]), 64'h77);
        chk("in_nb_a", 64'(if_a.nbusy), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
